// File: rtl/dco_pkg.sv
// Shared types and default sizes for the programmable DCO.
// Latency: n/a (types only).
// Backpressure: n/a.
package dco_pkg;

  typedef enum logic {
    DCO_MODE_DIV = 1'b0,
    DCO_MODE_NCO = 1'b1
  } dco_mode_e;

  localparam int DCO_CODE_W = 8;
  localparam int DCO_ACC_W  = 24;

  // Default-width configuration word. Modules built with a non-default
  // CODE_W declare the same {mode, code} layout at their own width.
  typedef struct packed {
    dco_mode_e             mode;
    logic [DCO_CODE_W-1:0] code;
  } dco_cfg_t;

endpackage

// File: rtl/dco_code_shadow.sv
// Pending/active configuration pair; updates land only when the datapath says so.
// Latency: load visible on pending after 1 edge; apply copies pending to active on the apply edge.
// Backpressure: none; a load while pending overwrites (last write wins).
// Ports: clk_i/reset_i; load/load_mode/load_code capture a request; apply promotes it;
//        act_mode/act_code drive the datapath; pend_mode lets it spot a mode change;
//        pending flags an unapplied request.
module dco_code_shadow
  import dco_pkg::*;
#(
  parameter int                 CODE_W     = DCO_CODE_W,
  parameter logic [CODE_W-1:0]  RESET_CODE = CODE_W'(255),
  parameter dco_mode_e          RESET_MODE = DCO_MODE_DIV
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load,
  input  dco_mode_e         load_mode,
  input  logic [CODE_W-1:0] load_code,
  input  logic              apply,
  output dco_mode_e         act_mode,
  output logic [CODE_W-1:0] act_code,
  output dco_mode_e         pend_mode,
  output logic              pending
);

  typedef struct packed {
    dco_mode_e         mode;
    logic [CODE_W-1:0] code;
  } cfg_t;

  cfg_t pend_cfg;
  cfg_t act_cfg;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pend_cfg <= '{mode: DCO_MODE_DIV, code: '0};
      act_cfg  <= '{mode: RESET_MODE, code: RESET_CODE};
      pending  <= 1'b0;
    end else begin
      // Apply consumes the value that was pending before this edge; a load
      // on the same edge becomes the next pending value and stays pending.
      if (apply) begin
        act_cfg <= pend_cfg;
      end
      if (load) begin
        pend_cfg <= '{mode: load_mode, code: load_code};
        pending  <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  assign act_mode  = act_cfg.mode;
  assign act_code  = act_cfg.code;
  assign pend_mode = pend_cfg.mode;

endmodule

// File: rtl/param_dco.sv
// Programmable clock generator: integer half-period divider or phase-accumulator NCO.
// Latency: first counter/accumulator step on the edge after enable rises; outputs registered.
// Backpressure: none; enable_i low freezes all state, config loads still captured.
// Ports: clk_i, reset_i (async active-low), enable_i, mode_i/freqCode_i/codeLoad_i request
//        a new config, codePending_o shows it is not yet applied, signal_o is the generated
//        output, tick_o pulses on the cycle signal_o first reads 1. ACC_W must be >= CODE_W.
module param_dco
  import dco_pkg::*;
#(
  parameter int                 CODE_W     = DCO_CODE_W,
  parameter int                 ACC_W      = DCO_ACC_W,
  parameter logic [CODE_W-1:0]  RESET_CODE = CODE_W'(255),
  parameter dco_mode_e          RESET_MODE = DCO_MODE_DIV
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              mode_i,
  input  logic [CODE_W-1:0] freqCode_i,
  input  logic              codeLoad_i,
  output logic              codePending_o,
  output logic              signal_o,
  output logic              tick_o
);

  dco_mode_e         act_mode;
  dco_mode_e         pend_mode;
  logic [CODE_W-1:0] act_code;
  logic              apply;

  logic [CODE_W-1:0] cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic              cnt_hit;
  logic              boundary;

  logic [CODE_W-1:0] cnt_nxt;
  logic [ACC_W-1:0]  acc_nxt;
  logic              sig_nxt;

  dco_code_shadow #(
    .CODE_W     (CODE_W),
    .RESET_CODE (RESET_CODE),
    .RESET_MODE (RESET_MODE)
  ) u_shadow (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load      (codeLoad_i),
    .load_mode (dco_mode_e'(mode_i)),
    .load_code (freqCode_i),
    .apply     (apply),
    .act_mode  (act_mode),
    .act_code  (act_code),
    .pend_mode (pend_mode),
    .pending   (codePending_o)
  );

  // Boundary = the only cycle where a config swap cannot cut a pulse short:
  // divider toggle, or NCO carry-out. A zero NCO code never carries, so every
  // cycle is treated as a boundary to keep such a config replaceable.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, ACC_W'(act_code)};
    cnt_hit = (cnt == act_code);
    if (act_mode == DCO_MODE_DIV) begin
      boundary = cnt_hit;
    end else begin
      boundary = sum[ACC_W] || (act_code == '0);
    end
  end

  assign apply = enable_i && boundary && codePending_o;

  always_comb begin
    cnt_nxt = cnt;
    acc_nxt = acc;
    sig_nxt = signal_o;
    if (apply && (pend_mode != act_mode)) begin
      // Mode change restarts both datapaths from a known low phase.
      cnt_nxt = '0;
      acc_nxt = '0;
      sig_nxt = 1'b0;
    end else if (act_mode == DCO_MODE_DIV) begin
      if (cnt_hit) begin
        cnt_nxt = '0;
        sig_nxt = ~signal_o;
      end else begin
        cnt_nxt = cnt + CODE_W'(1);
      end
    end else begin
      acc_nxt = sum[ACC_W-1:0];
      sig_nxt = sum[ACC_W-1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt      <= '0;
      acc      <= '0;
      signal_o <= 1'b0;
      tick_o   <= 1'b0;
    end else if (enable_i) begin
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      signal_o <= sig_nxt;
      tick_o   <= sig_nxt & ~signal_o;
    end else begin
      tick_o   <= 1'b0;
    end
  end

endmodule

// File: doc/param_dco.md
# param_dco

Parametrised, synthesizable successor to the black-box DCO model. It generates `signal_o` from the system clock in one of two runtime-selectable modes:

- **Integer divider:** programmable half-period.
- **Phase-accumulator NCO:** fractional frequency, output = accumulator MSB.

Frequency and mode updates are glitch-free. They are shadowed and take effect only at an output period boundary. The block sits wherever a programmable test or reference clock is required and replaces the fixed-period model in benches and in synthesizable paths.

## Interface
Parameters:
- `CODE_W`, 8, width of the frequency code and of the divider counter.
- `ACC_W`, 24, NCO accumulator width; must be ≥ `CODE_W`.
- `RESET_CODE`, `CODE_W`'d255, active code after reset.
- `RESET_MODE`, `DCO_MODE_DIV`, active mode after reset.

Ports:
- `clk_i`  in  1  system clock, all logic on its rising edge.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  run; low freezes counter, accumulator and output.
- `mode_i`  in  1  requested mode (0 = divider, 1 = NCO), sampled with `codeLoad_i`.
- `freqCode_i`  in  `CODE_W`  requested code, sampled with `codeLoad_i`.
- `codeLoad_i`  in  1  one-cycle strobe, captures {`mode_i`, `freqCode_i`} into the pending register.
- `codePending_o`  out  1  pending update not yet applied.
- `signal_o`  out  1  generated output, registered.
- `tick_o`  out  1  one-cycle pulse, registered, high in the first cycle `signal_o` is 1.

## Operation
- **Reset:** asynchronous while `reset_i` = 0.
  - Active code = `RESET_CODE`, active mode = `RESET_MODE`.
  - Counter, accumulator, `signal_o`, `tick_o`, `codePending_o` and the pending register all = 0.
- **Divider mode, active code C:**
  - Counter counts 0..C.
  - At counter == C: counter ← 0 and `signal_o` toggles.
  - Half-period = C+1 cycles, period = 2(C+1). C = 0 gives clk/2.
  - Boundary = the toggle cycle.
- **NCO mode:**
  - Accumulator ← accumulator + C, where C is zero-extended to `ACC_W` and the sum wraps modulo 2^`ACC_W`.
  - `signal_o` = MSB of the next accumulator value (registered).
  - f_out = f_clk·C/2^`ACC_W`.
  - Boundary = a cycle whose addition carries out of `ACC_W` bits.
  - If the active code is 0 (no carry ever occurs), every enabled cycle counts as a boundary.
- **Updates:**
  - A load sets the pending register and `codePending_o`.
  - Load while pending: last write wins; `codePending_o` stays 1.
  - At the first enabled boundary after the load edge, pending → active and `codePending_o` ← 0.
  - A load on the same edge as an apply replaces the pending value and remains pending; the apply uses the old pending value.
- **Apply with unchanged mode:**
  - That edge completes the normal update with the old code: divider counter ← 0 with toggle, or NCO addition with the old C.
  - The new code governs from the next cycle.
- **Apply with changed mode:**
  - Counter ← 0, accumulator ← 0, `signal_o` ← 0 instead of the normal update.
- **`enable_i` = 0:**
  - All state holds, no boundary occurs, `tick_o` = 0.
  - Loads are still captured.

## Timing
- Load at edge k: `codePending_o` = 1 after edge k. Earliest apply is edge k+1, evaluated against the old state.
- `tick_o` asserts on the same edge as the 0→1 transition of `signal_o`, for exactly 1 cycle. It is 0 on a mode-change apply.
- Output latency from the enable rise: the first counter or accumulator step occurs at the next edge.
- Reset deasserted mid-period: the restart is identical to power-up. Pending content is lost.

## Structure
- Package `dco_pkg`:
  - `dco_mode_e` (`DCO_MODE_DIV` = 1'b0, `DCO_MODE_NCO` = 1'b1).
  - Default `CODE_W`/`ACC_W` localparams.
  - Packed `dco_cfg_t` {mode, code}.
- Sub-module `dco_code_shadow`: pending/active `dco_cfg_t` register pair, load/apply arbitration, `codePending_o`. The top level contains the divider and NCO datapaths and the boundary logic.

## Test plan
- **Power-up:** `RESET_CODE` = 3, divider, enable = 1. Required: `signal_o` toggles every 4 cycles (period 8) and `tick_o` pulses every 8 cycles.
- **Divider update mid half-period:** active C = 3; load C = 1 when counter = 1. Required: `codePending_o` = 1 for 2 cycles, clearing at the counter == 3 toggle; subsequent half-periods are 2 cycles; no runt pulse.
- **NCO, `ACC_W` = 8:** C = 64 gives period 4 with 2 cycles high. C = 96 gives 3 periods every 8 cycles.
- **NCO with active C = 0:** load C = 10. Required: applied on the edge after load; the accumulator then increments by 10.
- **Mode switch:** divider C = 2, load {NCO, 32} at counter 0. Required: at the toggle edge, `signal_o` = 0, the accumulator = 0, no `tick_o`; the NCO runs afterwards.
- **Freeze and reset:** enable = 0 for 5 cycles holds all outputs. Assert reset mid-period with a load pending. Required: all outputs are 0 immediately and the pending update is discarded.
